pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline.
//  Freezes the whole pipeline on data-memory wait, inserts a load-use bubble,
//  and flushes IF/ID + ID/EX on a taken branch resolved in EX.
//  Sequences a halt/drain request and keeps saturating stall/flush perf counters.
//  Drives enable/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// PARAMETERS
//  REG_AW       5   register-address width
//  DRAIN_CYC    4   bubble cycles needed to empty pipeline on halt (>=1)
//  MEM_TIMEOUT  15  max consecutive MEM_WAIT cycles before mem_err (>=1)
//  CNT_W        16  width of perf counters
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       synchronous, active-high
//  id_rs1,id_rs2  in   REG_AW  source regs of instruction in ID
//  id_use_rs1/2   in   1       ID instruction actually reads rs1/rs2
//  ex_memRead     in   1       ID/EX holds a load
//  ex_rd          in   REG_AW  destination reg held in ID/EX
//  ex_br_taken    in   1       branch in EX resolved taken
//  mem_req        in   1       MEM stage issuing load/store this cycle
//  mem_ready      in   1       data memory completes access this cycle
//  halt_req       in   1       level request to drain and halt
//  pc_en,ifid_en  out  1       load enables for PC and IF/ID
//  idex_en,exmem_en out 1      load enables for ID/EX and EX/MEM
//  ifid_flush     out  1       load NOP into IF/ID
//  idex_bubble    out  1       load NOP (all controls 0) into ID/EX
//  memwb_bubble   out  1       load NOP into MEM/WB
//  halted         out  1       pipeline empty and stopped
//  mem_err        out  1       sticky: MEM_TIMEOUT exceeded
//  stall_cnt,flush_cnt out CNT_W  saturating perf counters
// BEHAVIOUR
//  State reg: RUN, MEM_WAIT, DRAIN, HALTED. Outputs combinational from state+inputs.
//  Reset (reset=1 at edge): state<=RUN, drain_cnt/wait_cnt/counters<=0, mem_err<=0.
//   While reset=1: all *_en=0, ifid_flush=idex_bubble=memwb_bubble=1, halted=0.
//  Default (no event): all *_en=1, flush/bubbles=0.
//  Priority per cycle: memstall > branch flush > load-use. memstall = mem_req&!mem_ready.
//  memstall (RUN/DRAIN): pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1; next MEM_WAIT
//   (DRAIN resumes after, drain_cnt held). In MEM_WAIT same outputs until mem_ready=1;
//   cycle with mem_ready=1 uses default outputs, returns to originating state.
//  wait_cnt counts MEM_WAIT cycles; at wait_cnt==MEM_TIMEOUT set mem_err (sticky until reset);
//   stall persists, no auto-abort.
//  Branch (ex_br_taken, no memstall): pc_en=1 (target load), ifid_flush=1, idex_bubble=1;
//   flush_cnt+1. Load-use suppressed same cycle.
//  Load-use: ex_memRead & ex_rd!=0 & ((id_use_rs1&id_rs1==ex_rd)|(id_use_rs2&id_rs2==ex_rd))
//   -> pc_en=0, ifid_en=0, idex_bubble=1 for that cycle; resolves next cycle (1 bubble).
//  halt_req in RUN (no memstall): next DRAIN, drain_cnt=0.
//  DRAIN: pc_en=0, ifid_flush=1; drain_cnt++ per non-stalled cycle; branch in DRAIN still
//   loads PC (pc_en=1) and flushes. drain_cnt==DRAIN_CYC-1 -> HALTED.
//  HALTED: halted=1, pc_en=ifid_en=0, ifid_flush=idex_bubble=1; halt_req=0 -> RUN next cycle.
//  halt_req dropped mid-DRAIN: drain completes, enters HALTED, exits next cycle.
//  stall_cnt +1 each cycle pc_en=0 outside HALTED/reset; counters saturate at 2^CNT_W-1.
//  ex_rd==0 never causes load-use stall.
// TESTING
//  lw x5 in EX, ID add x6,x5,x1 -> 1 cycle pc_en=0,idex_bubble=1; stall_cnt=1.
//  mem_req=1, mem_ready=0 for 3 cycles -> all *_en=0 3 cycles, memwb_bubble=1, then resume.
//  ex_br_taken=1 + load-use same cycle -> pc_en=1,ifid_flush=1,idex_bubble=1; flush_cnt=1.
//  halt_req=1 from RUN -> 4 DRAIN cycles, halted=1; drop halt_req -> RUN, pc_en=1.
//  mem_ready held 0 for 16 cycles -> mem_err=1 at wait_cnt==15, stays 1 until reset.
//  reset=1 mid-DRAIN with memstall -> next cycle RUN, counters 0, mem_err 0, halted 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze, load-use bubble,
// taken-branch flush, halt/drain sequencing and saturating stall/flush perf counters.
module pipeline_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int DRAIN_CYC   = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_memRead,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_br_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              halt_req,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              memwb_bubble,
    output logic              halted,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [WW-1:0]    WAIT_LAST  = WW'(MEM_TIMEOUT - 1);
    localparam logic [WW-1:0]    WAIT_MAX   = WW'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t        state;
    logic          ret_drain;
    logic [DW-1:0] drain_cnt;
    logic [WW-1:0] wait_cnt;
    logic          memstall;
    logic          load_use;
    logic          br_flush;
    logic          stall_evt;

    assign memstall = mem_req & ~mem_ready;
    assign load_use = ex_memRead && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign halted    = ~reset && (state == HALTED);
    assign stall_evt = ~reset && (state != HALTED) && ~pc_en;

    // Priority inside RUN/DRAIN: memory stall, then branch flush, then load-use bubble.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        br_flush     = 1'b0;
        if (reset) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end else begin
            case (state)
                RUN, DRAIN: begin
                    if (memstall) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                    end else begin
                        if (state == DRAIN) begin
                            pc_en      = 1'b0;
                            ifid_flush = 1'b1;
                        end
                        if (ex_br_taken) begin
                            pc_en       = 1'b1;
                            ifid_flush  = 1'b1;
                            idex_bubble = 1'b1;
                            br_flush    = 1'b1;
                        end else if (load_use) begin
                            pc_en       = 1'b0;
                            ifid_en     = 1'b0;
                            idex_bubble = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                    end
                end
                HALTED: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ret_drain remembers whether a memory wait interrupted a drain so it can resume there.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            ret_drain <= 1'b0;
            drain_cnt <= '0;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
            if (br_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
            case (state)
                RUN: begin
                    if (memstall) begin
                        state     <= MEM_WAIT;
                        ret_drain <= 1'b0;
                        wait_cnt  <= '0;
                    end else if (halt_req) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= ret_drain ? DRAIN : RUN;
                        wait_cnt <= '0;
                    end else begin
                        if (wait_cnt == WAIT_LAST) mem_err <= 1'b1;
                        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (memstall) begin
                        state     <= MEM_WAIT;
                        ret_drain <= 1'b1;
                        wait_cnt  <= '0;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state <= HALTED;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                HALTED: begin
                    if (!halt_req) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
